// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - decode-stage issue controller with 2-entry FIFO and CSR serialization
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready / in_instr / in_pc     : fetch side, enqueue into FIFO
//   out_valid / out_ready / out_instr / out_pc : decode side, head of FIFO
//   out_imm_type / out_is_csr                  : classification stored with the head entry
//   flush                                      : drop all buffered instructions
//   csr_done / csr_busy                        : CSR writeback pulse / CSR op outstanding
//
// ImmGenType encoding: 0 NoGen, 1 Gen_1, 2 Gen_2, 3 Gen_3, 4 Gen_4, 5 Gen_5, 6 Gen_CSR.
module decode_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [2:0]  out_imm_type,
  output logic        out_is_csr,
  input  logic        flush,
  input  logic        csr_done,
  output logic        csr_busy
);

  localparam logic [2:0] IMM_NOGEN = 3'd0;
  localparam logic [2:0] IMM_GEN_1 = 3'd1;
  localparam logic [2:0] IMM_GEN_2 = 3'd2;
  localparam logic [2:0] IMM_GEN_3 = 3'd3;
  localparam logic [2:0] IMM_GEN_4 = 3'd4;
  localparam logic [2:0] IMM_GEN_5 = 3'd5;
  localparam logic [2:0] IMM_CSR   = 3'd6;

  localparam logic [0:0] ST_ISSUE    = 1'b0;
  localparam logic [0:0] ST_CSR_WAIT = 1'b1;

  logic [31:0] instr_q [2];
  logic [63:0] pc_q    [2];
  logic [2:0]  imm_q   [2];
  logic        csr_q   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [0:0]  state;

  logic [2:0]  enq_imm;
  logic        enq_csr;
  logic        push;
  logic        pop;

  // Classify at enqueue so the head outputs come straight from storage.
  always_comb begin
    enq_imm = IMM_NOGEN;
    enq_csr = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: enq_imm = IMM_GEN_1;
      7'b0110111, 7'b0010111:                         enq_imm = IMM_GEN_2;
      7'b1100011:                                     enq_imm = IMM_GEN_3;
      7'b0100011:                                     enq_imm = IMM_GEN_4;
      7'b1101111:                                     enq_imm = IMM_GEN_5;
      7'b1110011: begin
        // funct3 == 000 is ecall/ebreak/xret, not a CSR access
        if (in_instr[14:12] != 3'b000) begin
          enq_imm = IMM_CSR;
          enq_csr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // in_ready depends only on the stored count, so a pop cannot free a full slot in the same cycle.
  assign in_ready     = (count != 2'(DEPTH));
  assign out_valid    = (state == ST_ISSUE) && (count != 2'd0);
  assign csr_busy     = (state == ST_CSR_WAIT);
  assign out_instr    = instr_q[rd_ptr];
  assign out_pc       = pc_q[rd_ptr];
  assign out_imm_type = imm_q[rd_ptr];
  assign out_is_csr   = csr_q[rd_ptr];

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= IMM_NOGEN;
        csr_q[i]   <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      state  <= ST_ISSUE;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= in_instr;
        pc_q[wr_ptr]    <= in_pc;
        imm_q[wr_ptr]   <= enq_imm;
        csr_q[wr_ptr]   <= enq_csr;
      end

      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + 2'(push) - 2'(pop);
      end

      // Flush leaves the state alone: an already-issued CSR op still has to write back.
      case (state)
        ST_ISSUE:    if (pop && out_is_csr) state <= ST_CSR_WAIT;
        ST_CSR_WAIT: if (csr_done) state <= ST_ISSUE;
        default:     state <= ST_ISSUE;
      endcase
    end
  end

endmodule
